regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, data width in bits; NREG, default 32, register count (power of two, 2..64); AW = log2(NREG), derived, never overridden.
REQ-002 Port list SHALL be, clock and reset first: clk  in  1  clock; one clock only, all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 wb0_en / wb1_en  in  1 each  writeback port enables.
REQ-005 wb0_rd / wb1_rd  in  AW each  writeback destinations; wb0_data / wb1_data  in  XLEN each  writeback data.
REQ-006 iss_valid  in  1, iss_rd  in  AW, iss_ready  out  1  issue handshake that reserves a destination.
REQ-007 rs1 / rs2  in  AW each  read addresses; rs1_data / rs2_data  out  XLEN each  read data.
REQ-008 rs1_busy / rs2_busy  out  1 each  source has a pending producer.
REQ-009 busy_cnt  out  AW+1  number of registers currently reserved.

Function
REQ-010 Register 0 SHALL always read 0, never be written, never be busy; writes or issues to it are discarded without error, and an issue to it always completes (iss_ready=1).
REQ-011 Writes SHALL be synchronous: wbN_en=1 and wbN_rd!=0 loads wbN_data into wbN_rd at the clock edge.
REQ-012 wb0 and wb1 to the same nonzero rd in one cycle: wb1 data SHALL win; busy cleared once.
REQ-013 Reads SHALL be combinational, zero latency, rs*_data = register contents (subject to REQ-021).
REQ-014 Scoreboard: one busy bit per register; a writeback to rd SHALL clear busy[rd] at the edge.
REQ-015 iss_ready SHALL be combinational: 1 when iss_rd==0, or busy[iss_rd]==0, or a writeback to iss_rd is enabled this cycle; otherwise 0.
REQ-016 An issue completes when iss_valid & iss_ready; busy[iss_rd] (iss_rd!=0) SHALL be set at that edge.
REQ-017 Issue and writeback to the same rd in one cycle: register data updated, busy SHALL end set (new producer wins).
REQ-018 iss_valid with iss_ready=0: no state change; requester holds iss_valid/iss_rd until accepted.
REQ-019 rs*_busy SHALL equal busy[rs*] (0 for rs*==0), subject to REQ-021.
REQ-020 busy_cnt SHALL be a registered counter equal to popcount(busy) after every edge: +1 on accepted new reservation, -1 per distinct cleared register, net change computed in one cycle, never wraps (range 0..NREG-1).

Reset
REQ-022 rst_n low SHALL immediately and asynchronously clear all registers to 0, all busy bits to 0, busy_cnt to 0; outputs read 0 / not busy while asserted.
REQ-023 Reset asserted mid-operation SHALL discard pending reservations and same-cycle writes; first edge after deassertion behaves as from power-up.

Configuration
REQ-021 Macro REGFILE_BYPASS_EN: defined -> a read whose address matches an enabled nonzero writeback this cycle SHALL return that writeback's data (wb1 priority) and report busy=0; undefined -> reads return pre-edge contents and registered busy, forwarding is left to the pipeline.

Verification
REQ-024 Reset then read all addresses -> every rs*_data=0, rs*_busy=0, busy_cnt=0.
REQ-025 Issue rd=5, then wb0 rd=5 data=0xDEADBEEF two cycles later -> rs1_busy=1 and busy_cnt=1 in between; afterwards rs1_data=0xDEADBEEF, busy=0, busy_cnt=0.
REQ-026 Issue rd=7 while busy[7]=1 and no wb to 7 -> iss_ready=0, busy_cnt unchanged; same cycle with wb1 rd=7 -> iss_ready=1, busy[7] remains 1, busy_cnt unchanged.
REQ-027 wb0 and wb1 both to rd=3 with 0x11111111 / 0x22222222 -> reg 3 = 0x22222222; writes/issue to rd=0 -> reads 0, busy_cnt unchanged.
REQ-028 With REGFILE_BYPASS_EN: wb0 rd=9 data=0xA5A5A5A5, rs2=9 same cycle -> rs2_data=0xA5A5A5A5, rs2_busy=0; without macro -> old value and registered busy.
REQ-029 Reserve 4 registers, assert rst_n low between edges -> outputs clear immediately; after release busy_cnt=0, all iss_ready=1.

Source files
------------

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb -- two-write / two-read register file with a per-register
// scoreboard for an in-order issue pipeline.
//
// Register 0 is hardwired to zero and can never be reserved. An issue reserves
// its destination (sets the busy bit). A writeback fills the register and
// releases the reservation. busy_cnt tracks how many registers are reserved.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   -> a read whose address matches an enabled nonzero writeback in
//                the same cycle returns that writeback's data (wb1 wins) and
//                reports not-busy.
//   undefined -> reads return the pre-edge register contents and the
//                registered busy bit; forwarding is left to the pipeline.
//
// Parameters:
//   XLEN  data width in bits
//   NREG  register count (power of two, 2..64)
//   AW    log2(NREG), derived
//
// Ports:
//   clk                 clock, all state updates on the rising edge
//   rst_n               asynchronous active-low reset
//   wb0_en/wb1_en       writeback enables
//   wb0_rd/wb1_rd       writeback destinations
//   wb0_data/wb1_data   writeback data
//   iss_valid, iss_rd   issue request reserving iss_rd
//   iss_ready           issue can be accepted this cycle (combinational)
//   rs1/rs2             read addresses
//   rs1_data/rs2_data   read data (combinational)
//   rs1_busy/rs2_busy   read source has a pending producer
//   busy_cnt            number of registers currently reserved (registered)
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb0_en,
    input  logic [AW-1:0]   wb0_rd,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_en,
    input  logic [AW-1:0]   wb1_rd,
    input  logic [XLEN-1:0] wb1_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     busy_cnt
);

    // -------------------------------------------------------------------------
    // Writeback / issue qualification. Anything aimed at register 0 is
    // discarded here so the rest of the logic never needs to special-case it.
    // -------------------------------------------------------------------------
    logic wb0_act;
    logic wb1_act;
    logic iss_acc;

    assign wb0_act = wb0_en && (wb0_rd != '0);
    assign wb1_act = wb1_en && (wb1_rd != '0);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A pending writeback to the requested destination frees the slot in the
    // same cycle, so the new producer can take over the reservation at once.
    assign iss_ready = (iss_rd == '0)
                    || !busy_q[iss_rd]
                    || (wb0_en && (wb0_rd == iss_rd))
                    || (wb1_en && (wb1_rd == iss_rd));

    assign iss_acc = iss_valid && iss_ready && (iss_rd != '0);

    // -------------------------------------------------------------------------
    // Register storage. Each register is its own flop bank (asynchronous
    // reset rules out block RAM). wb1 has priority on a same-rd collision.
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] reg_val [NREG];

    assign reg_val[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            logic [XLEN-1:0] data_q;
            logic            hit0;
            logic            hit1;

            assign hit0 = wb0_act && (wb0_rd == AW'(gi));
            assign hit1 = wb1_act && (wb1_rd == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (hit1) begin
                    data_q <= wb1_data;
                end else if (hit0) begin
                    data_q <= wb0_data;
                end
            end

            assign reg_val[gi] = data_q;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Scoreboard. Clear on writeback first, then set on issue, so an issue and
    // a writeback to the same rd leave the bit set (new producer wins).
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if ((wb0_act && (wb0_rd == AW'(i))) || (wb1_act && (wb1_rd == AW'(i)))) begin
                busy_d[i] = 1'b0;
            end
            if (iss_acc && (iss_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Reservation counter. Net change per cycle:
    //   +1 when an accepted issue reserves a register that was free,
    //   -1 for each distinct busy register released by a writeback that is not
    //      immediately re-reserved by a same-cycle issue.
    // wb0 is ignored when wb1 targets the same rd so a double write clears once.
    // -------------------------------------------------------------------------
    logic [AW:0] busy_cnt_q;
    logic [AW:0] busy_cnt_d;
    logic        cnt_inc;
    logic        cnt_dec0;
    logic        cnt_dec1;

    assign cnt_inc  = iss_acc && !busy_q[iss_rd];

    assign cnt_dec0 = wb0_act && busy_q[wb0_rd]
                   && !(iss_acc && (iss_rd == wb0_rd))
                   && !(wb1_act && (wb1_rd == wb0_rd));

    assign cnt_dec1 = wb1_act && busy_q[wb1_rd]
                   && !(iss_acc && (iss_rd == wb1_rd));

    assign busy_cnt_d = busy_cnt_q + (AW+1)'(cnt_inc)
                                   - (AW+1)'(cnt_dec0)
                                   - (AW+1)'(cnt_dec1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // -------------------------------------------------------------------------
    // Read ports. Register 0 reads zero / not busy through reg_val[0] and
    // busy_q[0]. The reset gate keeps a same-cycle bypass from leaking data
    // while rst_n is held low.
    // -------------------------------------------------------------------------
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];

    assign rd_addr[0] = rs1;
    assign rd_addr[1] = rs2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [XLEN-1:0] data_c;
            logic            busy_c;

            always_comb begin
                data_c = reg_val[rd_addr[gi]];
                busy_c = busy_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                if (wb0_act && (wb0_rd == rd_addr[gi])) begin
                    data_c = wb0_data;
                    busy_c = 1'b0;
                end
                if (wb1_act && (wb1_rd == rd_addr[gi])) begin
                    data_c = wb1_data;
                    busy_c = 1'b0;
                end
`else
                // Writebacks become visible only after the edge.
`endif
                if (!rst_n) begin
                    data_c = '0;
                    busy_c = 1'b0;
                end
            end

            assign rd_data[gi] = data_c;
            assign rd_busy[gi] = busy_c;
        end
    endgenerate

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign rs1_busy = rd_busy[0];
    assign rs2_busy = rd_busy[1];

endmodule
